// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter block: register offsets, CTRL
// bit positions, mode encodings and FSM state encoding.
package timer_counter_pkg;

    localparam logic [1:0] REG_CTRL   = 2'b00;
    localparam logic [1:0] REG_PRESET = 2'b01;
    localparam logic [1:0] REG_COUNT  = 2'b10;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int PRESCALE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_e;

    // Reserved CTRL bits always read back as zero.
    function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode, input logic im);
        return {28'd0, im, mode, en};
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of the timer: address, byte enables, write data and
// write enable in; read data and level interrupt out.
interface timer_counter_if;
    logic [31:0] Addr;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Irq;

    modport master (output Addr, WE, BE, WD, input RD, Irq);
    modport slave  (input Addr, WE, BE, WD, output RD, Irq);
endinterface

// File: rtl/timer_counter_prescaler.sv
// Count-tick divider for timer_counter; only built when TIMER_PRESCALE_EN
// is defined. tick is high once every PRESCALE cycles while run is high.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
    import timer_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 32'd1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] DIV_LAST = PRESCALE_W'(PRESCALE - 32'd1);

    logic [PRESCALE_W-1:0] div_r;

    assign tick = run && (div_r == DIV_LAST);

    // Divider restarts on clear and holds whenever run is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r <= {PRESCALE_W{1'b0}};
        end else if (clear) begin
            div_r <= {PRESCALE_W{1'b0}};
        end else if (run) begin
            if (div_r == DIV_LAST) begin
                div_r <= {PRESCALE_W{1'b0}};
            end else begin
                div_r <= div_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            div_r <= div_r;
        end
    end

endmodule
`endif

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with CTRL/PRESET/COUNT registers.
// Define TIMER_PRESCALE_EN to divide count ticks by the PRESCALE parameter.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 32'd1
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);

    state_e      state_r;
    logic        ctrl_en_r;
    logic [1:0]  ctrl_mode_r;
    logic        ctrl_im_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;
    logic        irq_pend_r;

    logic        tick_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic [31:0] rd_s;
    logic        unused_addr_s;

    assign unused_addr_s = ^{bus.Addr[31:4], bus.Addr[1:0]};
    assign wr_ctrl_s     = bus.WE && (bus.Addr[3:2] == REG_CTRL);
    assign wr_preset_s   = bus.WE && (bus.Addr[3:2] == REG_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic pre_clear_s;
    logic pre_run_s;

    assign pre_clear_s = (state_r == ST_LOAD);
    assign pre_run_s   = (state_r == ST_CNT);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (pre_clear_s),
        .run   (pre_run_s),
        .tick  (tick_s)
    );
`else
    localparam int unsigned unused_prescale_p = PRESCALE;
    assign tick_s = 1'b1;
`endif

    // FSM and register file; CPU writes come last so they override the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ctrl_en_r   <= 1'b0;
            ctrl_mode_r <= MODE_ONESHOT;
            ctrl_im_r   <= 1'b0;
            preset_r    <= 32'd0;
            count_r     <= 32'd0;
            irq_pend_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ctrl_en_r) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    count_r <= preset_r;
                    state_r <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en_r) begin
                        state_r <= ST_IDLE;
                    end else if (tick_s) begin
                        // COUNT of 0 or 1 both expire, so COUNT never wraps.
                        if (count_r > 32'd1) begin
                            count_r <= count_r - 32'd1;
                        end else begin
                            count_r    <= 32'd0;
                            irq_pend_r <= 1'b1;
                            state_r    <= ST_INT;
                        end
                    end else begin
                        state_r <= ST_CNT;
                    end
                end
                ST_INT: begin
                    if (ctrl_mode_r == MODE_RELOAD) begin
                        irq_pend_r <= 1'b0;
                        state_r    <= ST_LOAD;
                    end else begin
                        ctrl_en_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (wr_ctrl_s && bus.BE[0]) begin
                ctrl_en_r   <= bus.WD[CTRL_EN_BIT];
                ctrl_mode_r <= bus.WD[CTRL_MODE_LSB +: 2];
                ctrl_im_r   <= bus.WD[CTRL_IM_BIT];
            end
            for (int i = 0; i < 4; i++) begin
                if (wr_preset_s && bus.BE[i]) begin
                    preset_r[i*8 +: 8] <= bus.WD[i*8 +: 8];
                end
            end
            if (wr_ctrl_s || wr_preset_s) begin
                irq_pend_r <= 1'b0;
            end
        end
    end

    // Read mux on the word offset; the reserved slot reads zero.
    always_comb begin
        rd_s = 32'd0;
        case (bus.Addr[3:2])
            REG_CTRL:   rd_s = ctrl_word(ctrl_en_r, ctrl_mode_r, ctrl_im_r);
            REG_PRESET: rd_s = preset_r;
            REG_COUNT:  rd_s = count_r;
            default:    rd_s = 32'd0;
        endcase
    end

    assign bus.RD  = rd_s;
    assign bus.Irq = ctrl_im_r & irq_pend_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register-access vector table,
// hand-written timing sequences and randomized runs against a timing model.
module tb_timer_counter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    timer_counter_if bus_if();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd_addr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus_if.WE   = 1'b0;
        bus_if.Addr = addr;
        #1;
        check32(name, bus_if.RD, exp);
    endtask

    task automatic irq_chk(input string name, input logic exp);
        check32(name, {31'd0, bus_if.Irq}, {31'd0, exp});
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        bus_if.WE   = 1'b1;
        bus_if.Addr = addr;
        bus_if.BE   = be;
        bus_if.WD   = wd;
        step();
        bus_if.WE   = 1'b0;
    endtask

    task automatic do_reset();
        bus_if.WE = 1'b0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] sel);
        logic [31:0] r;
        r = $urandom();
        return {r[31:4], sel, r[1:0]};
    endfunction

    // Expected state t edges after the enabling CTRL write, derived from the
    // documented timing: LOAD one edge later, N count edges, then the expiry.
    task automatic model_at(input int t, input int n, input logic [1:0] mode, input logic im,
                            output logic [31:0] ctrl, output logic [31:0] cnt, output logic pend);
        int nn;
        int p;
        logic en;
        logic reload;
        nn     = (n == 0) ? 1 : n;
        reload = (mode == 2'b01);
        if (t == 0) begin
            cnt  = 32'd0;
            pend = 1'b0;
            en   = 1'b1;
        end else begin
            p    = reload ? ((t - 1) % (nn + 2)) : (t - 1);
            cnt  = (p >= 1 && p <= nn) ? 32'(n - (p - 1)) : 32'd0;
            pend = reload ? (p == nn + 1) : (p >= nn + 1);
            en   = reload ? 1'b1 : (p < nn + 2);
        end
        ctrl = {28'd0, im, mode, en};
    endtask

    initial begin
        logic [31:0] e_ctrl;
        logic [31:0] e_cnt;
        logic [31:0] e_rd;
        logic [31:0] r;
        logic        e_pend;
        logic [1:0]  mode;
        logic [1:0]  sel;
        logic        im;
        int          n;
        int          k;
        int          exp_os[4];
        int          exp_ar[4];

        bus_if.Addr = 32'd0;
        bus_if.WE   = 1'b0;
        bus_if.BE   = 4'h0;
        bus_if.WD   = 32'd0;
        #1;
        read_chk("reset_count", 32'h8, 32'd0);
        read_chk("reset_ctrl", 32'h0, 32'd0);
        irq_chk("reset_irq", 1'b0);
        step();
        reset = 1'b0;

        // Register access, byte enables and read-only slots (Enable stays 0).
        vecs[0]  = '{1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b0, 32'h0,        4'h0, 32'h0,        32'h4,        32'h0};
        vecs[2]  = '{1'b0, 32'h0,        4'h0, 32'h0,        32'h8,        32'h0};
        vecs[3]  = '{1'b0, 32'h0,        4'h0, 32'h0,        32'hC,        32'h0};
        vecs[4]  = '{1'b1, 32'h4,        4'h3, 32'hAABBCCDD, 32'h4,        32'h0000CCDD};
        vecs[5]  = '{1'b1, 32'h4,        4'h8, 32'h11223344, 32'h4,        32'h1100CCDD};
        vecs[6]  = '{1'b1, 32'h8,        4'hF, 32'hFFFFFFFF, 32'h8,        32'h0};
        vecs[7]  = '{1'b1, 32'hC,        4'hF, 32'hFFFFFFFF, 32'hC,        32'h0};
        vecs[8]  = '{1'b1, 32'h0,        4'hF, 32'hFFFFFFF0, 32'h0,        32'h0};
        vecs[9]  = '{1'b1, 32'h0,        4'hE, 32'h000000F6, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 32'h0,        4'h1, 32'hFFFFFFF8, 32'h0,        32'h8};
        vecs[11] = '{1'b1, 32'h0,        4'h1, 32'h00000006, 32'h0,        32'h6};
        vecs[12] = '{1'b1, 32'h0,        4'hF, 32'h00000000, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 32'h0,        4'h0, 32'h0,        32'hFFFFFFF5, 32'h1100CCDD};
        vecs[14] = '{1'b1, 32'hFFFFFFF4, 4'h4, 32'h00EE0000, 32'h4,        32'h11EECCDD};
        for (int i = 0; i < 15; i++) begin
            bus_if.WE   = vecs[i].we;
            bus_if.Addr = vecs[i].addr;
            bus_if.BE   = vecs[i].be;
            bus_if.WD   = vecs[i].wd;
            step();
            bus_if.WE = 1'b0;
            read_chk($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
            irq_chk($sformatf("vec%0d_irq", i), 1'b0);
        end

        // Reset mid-count clears everything without a clock edge.
        do_reset();
        wr(32'h4, 4'hF, 32'd5);
        wr(32'h0, 4'hF, 32'h9);
        for (int i = 0; i < 4; i++) step();
        read_chk("midrst_count_pre", 32'h8, 32'd3);
        reset = 1'b1;
        read_chk("midrst_count", 32'h8, 32'd0);
        read_chk("midrst_ctrl", 32'h0, 32'd0);
        read_chk("midrst_preset", 32'h4, 32'd0);
        irq_chk("midrst_irq", 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        read_chk("postrst_count", 32'h8, 32'd0);
        irq_chk("postrst_irq", 1'b0);
        wr(32'h4, 4'hF, 32'd1);
        wr(32'h0, 4'hF, 32'h9);
        step(); step();
        read_chk("postrst_load", 32'h8, 32'd1);
        step();
        irq_chk("postrst_fire", 1'b1);

        // One-shot, PRESET=3.
        exp_os = '{3, 2, 1, 0};
        do_reset();
        wr(32'h4, 4'hF, 32'd3);
        wr(32'h0, 4'hF, 32'h9);
        irq_chk("os_irq_e0", 1'b0);
        read_chk("os_ctrl_e0", 32'h0, 32'h9);
        step();
        read_chk("os_cnt_e1", 32'h8, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            read_chk($sformatf("os_cnt_e%0d", i + 2), 32'h8, 32'(exp_os[i]));
            irq_chk($sformatf("os_irq_e%0d", i + 2), (i == 3));
        end
        step();
        read_chk("os_ctrl_done", 32'h0, 32'h8);
        irq_chk("os_irq_e6", 1'b1);
        step(); step();
        irq_chk("os_irq_hold", 1'b1);
        read_chk("os_cnt_hold", 32'h8, 32'd0);
        wr(32'h0, 4'hF, 32'h0);
        irq_chk("os_irq_clr", 1'b0);

        // Auto-reload, PRESET=2: period 4, COUNT 0(LOAD),2,1,0(INT).
        exp_ar = '{0, 2, 1, 0};
        do_reset();
        wr(32'h4, 4'hF, 32'd2);
        wr(32'h0, 4'hF, 32'hB);
        for (int t = 1; t <= 24; t++) begin
            step();
            read_chk($sformatf("ar_cnt_t%0d", t), 32'h8, 32'(exp_ar[(t - 1) % 4]));
            irq_chk($sformatf("ar_irq_t%0d", t), (t % 4 == 0));
        end

        // Masked expiry leaves Irq low; re-enable clears the stale pending.
        do_reset();
        wr(32'h4, 4'hF, 32'd1);
        wr(32'h0, 4'hF, 32'h1);
        for (int t = 1; t <= 6; t++) begin
            step();
            irq_chk($sformatf("mask_irq_t%0d", t), 1'b0);
        end
        read_chk("mask_cnt", 32'h8, 32'd0);
        read_chk("mask_ctrl", 32'h0, 32'd0);
        wr(32'h0, 4'hF, 32'h9);
        irq_chk("mask_irq_rewrite", 1'b0);
        step(); step();
        irq_chk("mask_irq_t2", 1'b0);
        step();
        irq_chk("mask_irq_refire", 1'b1);

        // CPU write to CTRL in the INT cycle beats the FSM clearing Enable.
        do_reset();
        wr(32'h4, 4'hF, 32'd2);
        wr(32'h0, 4'hF, 32'h9);
        for (int i = 0; i < 4; i++) step();
        irq_chk("cf_irq_int", 1'b1);
        wr(32'h0, 4'hF, 32'h9);
        read_chk("cf_ctrl", 32'h0, 32'h9);
        irq_chk("cf_irq_cleared", 1'b0);
        step();
        read_chk("cf_cnt_idle", 32'h8, 32'd0);
        step();
        read_chk("cf_cnt_load", 32'h8, 32'd2);
        step(); step();
        irq_chk("cf_irq_refire", 1'b1);

        // Randomized runs against the timing model.
        for (int s = 0; s < 40; s++) begin
            n    = $urandom_range(0, 6);
            mode = 2'($urandom_range(0, 3));
            im   = 1'($urandom_range(0, 1));
            k    = $urandom_range(8, 24);
            do_reset();
            wr(rand_addr(2'd1), 4'hF, 32'(n));
            r = $urandom();
            wr(rand_addr(2'd0), 4'hF, {r[31:4], im, mode, 1'b1});
            for (int t = 0; t <= k; t++) begin
                if (t > 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus_if.WE   = 1'b1;
                        bus_if.Addr = rand_addr(2'($urandom_range(2, 3)));
                        bus_if.BE   = 4'($urandom());
                        bus_if.WD   = $urandom();
                    end
                    step();
                    bus_if.WE = 1'b0;
                end
                model_at(t, n, mode, im, e_ctrl, e_cnt, e_pend);
                sel = 2'($urandom_range(0, 3));
                case (sel)
                    2'd0:    e_rd = e_ctrl;
                    2'd1:    e_rd = 32'(n);
                    2'd2:    e_rd = e_cnt;
                    default: e_rd = 32'd0;
                endcase
                read_chk($sformatf("rnd%0d_t%0d_rd%0d", s, t, sel), rand_addr(sel), e_rd);
                irq_chk($sformatf("rnd%0d_t%0d_irq", s, t), im & e_pend);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
